vend_ctrl: RTL

Sequencing controller for the vending machine. It accepts coin events, tracks credit against a fixed price, runs the vend handshake with the dispense mechanism and times the "get item" and "refund" display phases. It drives the 3-bit `status` code consumed by the LED output decoder, plus credit and change values for the display path.

---
 rtl/vend_if.sv | 23 ++
 rtl/vend_ctrl.sv | 121 ++++++++++++
 2 files changed

// File: rtl/vend_if.sv
// vend_if: vending controller I/O bundle; the master drives machine inputs and
// the slave, vend_ctrl, drives the status and display outputs.
interface vend_if;
   logic       power_sw;
   logic       coin_valid;
   logic [1:0] coin_sel;
   logic       select;
   logic       cancel;
   logic       vend_ack;
   logic [2:0] status;
   logic [7:0] credit;
   logic [7:0] change;
   logic       vend_req;
   logic       coin_reject;
   modport master (
      output power_sw, coin_valid, coin_sel, select, cancel, vend_ack,
      input  status, credit, change, vend_req, coin_reject
   );
   modport slave (
      input  power_sw, coin_valid, coin_sel, select, cancel, vend_ack,
      output status, credit, change, vend_req, coin_reject
   );
endinterface

// File: rtl/vend_ctrl.sv
// vend_ctrl: vending machine sequencer (credit, vend handshake, GET/BACK hold timing).
// Optional inactivity refund in COIN/ENOUGH is enabled by defining VEND_TIMEOUT_EN.
module vend_ctrl #(
   parameter logic [7:0]  PRICE          = 8'd25,
   parameter logic [7:0]  CREDIT_MAX     = 8'd99,
   parameter logic [15:0] HOLD_CYCLES    = 16'd100,
   parameter logic [15:0] TIMEOUT_CYCLES = 16'd1000
) (
   input logic   clk,
   input logic   rst,
   vend_if.slave bus
);
   typedef enum logic [2:0] {
      OFF    = 3'b000,
      IDLE   = 3'b001,
      COIN   = 3'b010,
      ENOUGH = 3'b011,
      VEND   = 3'b100,
      GET    = 3'b101,
      BACK   = 3'b110
   } state_e;
   state_e      state_q, state_d;
   logic [7:0]  credit_q, credit_d;
   logic [7:0]  change_q, change_d;
   logic [15:0] hold_q, hold_d;
   logic        vend_req_q, vend_req_d;
   logic        coin_reject_q, coin_reject_d;
   logic [8:0]  coin_val, sum;
   logic        fits, accept, active, activity, timeout;
   assign coin_val = bus.coin_sel == 2'd0 ? 9'd1 :
                     bus.coin_sel == 2'd1 ? 9'd5 :
                     bus.coin_sel == 2'd2 ? 9'd10 : 9'd20;
   assign sum      = {1'b0, credit_q} + coin_val;
   assign fits     = sum <= {1'b0, CREDIT_MAX};
   assign active   = state_q == COIN || state_q == ENOUGH;
   assign activity = bus.coin_valid || bus.select || bus.cancel;
`ifdef VEND_TIMEOUT_EN
   logic [15:0] idle_q, idle_d;
   assign idle_d  = active && !activity ? idle_q + 16'd1 : 16'd0;
   assign timeout = active && !activity && idle_d == TIMEOUT_CYCLES;
   always_ff @(posedge clk)
      if (rst) idle_q <= 16'd0;
      else     idle_q <= idle_d;
`else
   logic unused_timeout;
   assign unused_timeout = ^{TIMEOUT_CYCLES, active, activity};
   assign timeout = 1'b0;
`endif
   always_comb begin
      state_d  = state_q;
      credit_d = credit_q;
      change_d = change_q;
      hold_d   = hold_q;
      accept   = 1'b0;
      case (state_q)
         OFF: state_d = bus.power_sw ? IDLE : OFF;
         IDLE: begin
            if (!bus.power_sw) state_d = OFF;
            else if (bus.coin_valid && fits) begin
               accept   = 1'b1;
               credit_d = sum[7:0];
               state_d  = sum >= {1'b0, PRICE} ? ENOUGH : COIN;
            end
         end
         COIN, ENOUGH: begin
            // power loss and inactivity both refund exactly like cancel
            if (bus.cancel || !bus.power_sw || timeout) begin
               state_d  = BACK;
               change_d = credit_q;
               credit_d = 8'd0;
               hold_d   = 16'd0;
            end else if (bus.select && state_q == ENOUGH) state_d = VEND;
            else if (bus.coin_valid && fits) begin
               accept   = 1'b1;
               credit_d = sum[7:0];
               state_d  = sum >= {1'b0, PRICE} ? ENOUGH : COIN;
            end
         end
         VEND: begin
            if (bus.vend_ack) begin
               state_d  = GET;
               change_d = credit_q - PRICE;
               credit_d = 8'd0;
               hold_d   = 16'd0;
            end
         end
         GET, BACK: begin
            if (hold_q == HOLD_CYCLES - 16'd1) begin
               state_d  = bus.power_sw ? IDLE : OFF;
               change_d = 8'd0;
               hold_d   = 16'd0;
            end else hold_d = hold_q + 16'd1;
         end
         default: state_d = OFF;
      endcase
      vend_req_d    = state_d == VEND;
      coin_reject_d = bus.coin_valid && !accept;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= OFF;
         credit_q      <= 8'd0;
         change_q      <= 8'd0;
         hold_q        <= 16'd0;
         vend_req_q    <= 1'b0;
         coin_reject_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         credit_q      <= credit_d;
         change_q      <= change_d;
         hold_q        <= hold_d;
         vend_req_q    <= vend_req_d;
         coin_reject_q <= coin_reject_d;
      end
   end
   assign bus.status      = state_q;
   assign bus.credit      = credit_q;
   assign bus.change      = change_q;
   assign bus.vend_req    = vend_req_q;
   assign bus.coin_reject = coin_reject_q;
endmodule
